fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that lets N_REQ independent producers share the single write port of the 16-deep fifo_mem (wr, data_in, fifo_full).
- Each producer has a valid/ready handshake.
- A granted producer keeps the port for a burst of up to MAX_BURST words, then ownership rotates.
- Sits directly in front of fifo_mem. fifo_wr drives its wr input, fifo_data drives data_in, and fifo_full comes back from it.

---
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that lets N_REQ valid/ready producers share the single
//   write port of fifo_mem. Each grant lasts for a burst of up to MAX_BURST
//   words. After that, ownership rotates to the next valid producer with no
//   idle cycle between bursts.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - per-producer valid
//   req_data   - per-producer word, producer i at [i*DATA_W +: DATA_W]
//   req_ready  - per-producer ready (transfer = valid & ready)
//   fifo_full  - full flag from fifo_mem
//   fifo_wr    - write strobe to fifo_mem
//   fifo_data  - write data to fifo_mem
//   grant_id   - current owner index, 0 when idle
//   busy       - high while a burst is owned
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [DATA_W-1:0]       fifo_data,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [4:0]      cnt_q, cnt_d;

  logic            in_burst;
  logic            owner_valid;
  logic            xfer;
  logic            release_own;
  logic [ID_W-1:0] base;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  int unsigned     idx;

  assign in_burst    = (state_q == BURST);
  assign owner_valid = |(req_valid & (N_REQ'(1) << owner_q));
  assign xfer        = in_burst & owner_valid & ~fifo_full;
  // Stalling on a full FIFO never releases a still-valid owner.
  assign release_own = ~owner_valid | (xfer & (cnt_q == 5'(MAX_BURST - 1)));

  // Round-robin search from base+1 around to base itself. When releasing, base is
  // the current owner. The releasing owner is therefore only chosen again if no
  // other producer is valid.
  always_comb begin
    base       = in_burst ? owner_q : last_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = 32'(base) + k;
      if (idx >= NR) idx = idx - NR;
      if (!pick_found && ((req_valid & (N_REQ'(1) << idx)) != '0)) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BURST;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (xfer) cnt_d = cnt_q + 5'd1;
        if (release_own) begin
          last_d = owner_q;
          cnt_d  = '0;
          if (pick_found) owner_d = pick_idx;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = in_burst;
    grant_id  = in_burst ? owner_q : '0;
    fifo_wr   = xfer;
    req_ready = (in_burst && !fifo_full) ? (N_REQ'(1) << owner_q) : '0;
    fifo_data = in_burst ? DATA_W'(req_data >> (int'(owner_q) * DATA_W)) : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_wr_arbiter #(.N_REQ(4), .ID_W(2), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rem[4];
  int          sent[4];
  logic [7:0]  dbase[4];
  int          occ;
  int          ovf;
  logic        rd;
  logic [7:0]  wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (rem[i] > 0);
      req_data[i*8 +: 8] = dbase[i] + 8'(sent[i]);
    end
    fifo_full = (occ >= 16);
  endtask

  task automatic load(input int p, input int n, input logic [7:0] b);
    rem[p] = n; sent[p] = 0; dbase[p] = b;
    drive();
    #1;
  endtask

  // One clock: book the handshakes seen before the edge, then re-drive inputs.
  task automatic tick();
    logic [3:0] hs;
    logic       w;
    logic [7:0] d;
    hs = req_valid & req_ready;
    w  = fifo_wr;
    d  = fifo_data;
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (hs[i]) begin rem[i]--; sent[i]++; end
    if (w) begin
      if (fifo_full) ovf++;
      wlog.push_back(d);
    end
    occ = occ + (w ? 1 : 0) - ((rd && occ > 0) ? 1 : 0);
    #1; drive();
    #1;
  endtask

  task automatic cyc(input string tag, input logic b, input logic [1:0] g,
                     input logic w, input logic [7:0] d);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".gid"}, 32'(grant_id), 32'(g));
    chk({tag, ".wr"}, 32'(fifo_wr), 32'(w));
    if (w) chk({tag, ".data"}, 32'(fifo_data), 32'(d));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin rem[i] = 0; sent[i] = 0; dbase[i] = '0; end
    occ = 0; rd = 1'b0; wlog.delete();
    drive();
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; occ = 0; ovf = 0;
    for (int i = 0; i < 4; i++) begin rem[i] = 1; sent[i] = 0; dbase[i] = 8'(i); end
    drive();
    #12;
    chk("rst.ready", 32'(req_ready), 32'h0);
    chk("rst.wr", 32'(fifo_wr), 32'h0);
    chk("rst.data", 32'(fifo_data), 32'h0);
    chk("rst.gid", 32'(grant_id), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);

    // Single producer 2, six words: 4-word burst then self re-grant
    do_reset();
    load(2, 6, 8'h20);
    cyc("t1.idle", 1'b0, 2'd0, 1'b0, 8'h00);
    tick();
    chk("t1.ready", 32'(req_ready), 32'h4);
    for (int k = 0; k < 6; k++) begin
      cyc("t1.word", 1'b1, 2'd2, 1'b1, 8'h20 + 8'(k));
      tick();
    end
    cyc("t1.drop", 1'b1, 2'd2, 1'b0, 8'h00);
    tick();
    cyc("t1.end", 1'b0, 2'd0, 1'b0, 8'h00);
    chk("t1.count", 32'(wlog.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk("t1.order", 32'(wlog[k]), 32'(8'h20 + 8'(k)));

    // All four valid, reads every cycle: grants 0,1,2,3,0 x4 words, no gaps
    do_reset();
    rd = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 12, 8'(i * 8'h40));
    cyc("t2.idle", 1'b0, 2'd0, 1'b0, 8'h00);
    tick();
    for (int b = 0; b < 5; b++)
      for (int w = 0; w < 4; w++) begin
        cyc("t2.rr", 1'b1, 2'(b % 4), 1'b1, 8'((b % 4) * 8'h40 + (b == 4 ? 4 : 0) + w));
        tick();
      end

    // Producer 1 streams 20 words, no reads: FIFO fills after 16
    do_reset();
    load(1, 20, 8'h80);
    tick();
    for (int k = 0; k < 16; k++) begin
      cyc("t3.fill", 1'b1, 2'd1, 1'b1, 8'h80 + 8'(k));
      tick();
    end
    chk("t3.full", 32'(fifo_full), 32'h1);
    cyc("t3.stall", 1'b1, 2'd1, 1'b0, 8'h00);
    chk("t3.ready", 32'(req_ready), 32'h0);
    tick();
    cyc("t3.stall2", 1'b1, 2'd1, 1'b0, 8'h00);
    rd = 1'b1;
    tick();
    cyc("t3.w17", 1'b1, 2'd1, 1'b1, 8'h90);
    chk("t3.ready17", 32'(req_ready), 32'h2);
    tick();
    cyc("t3.w18", 1'b1, 2'd1, 1'b1, 8'h91);
    rd = 1'b0;
    tick();
    cyc("t3.refull", 1'b1, 2'd1, 1'b0, 8'h00);
    chk("t3.count", 32'(wlog.size()), 32'd18);

    // Early release: producer 0 stops after 2, skip to producer 3
    do_reset();
    load(0, 2, 8'hA0);
    load(3, 5, 8'hB0);
    tick();
    cyc("t4.a0", 1'b1, 2'd0, 1'b1, 8'hA0);
    tick();
    cyc("t4.a1", 1'b1, 2'd0, 1'b1, 8'hA1);
    tick();
    cyc("t4.rel", 1'b1, 2'd0, 1'b0, 8'h00);
    chk("t4.relready", 32'(req_ready), 32'h1);
    tick();
    cyc("t4.b0", 1'b1, 2'd3, 1'b1, 8'hB0);
    chk("t4.ready3", 32'(req_ready), 32'h8);

    // Async reset with producer 3 at cnt=2
    tick();
    cyc("t5.b1", 1'b1, 2'd3, 1'b1, 8'hB1);
    tick();
    cyc("t5.b2", 1'b1, 2'd3, 1'b1, 8'hB2);
    rst_n = 1'b0;
    #1;
    cyc("t5.rst", 1'b0, 2'd0, 1'b0, 8'h00);
    chk("t5.rstdata", 32'(fifo_data), 32'h0);
    chk("t5.rstready", 32'(req_ready), 32'h0);
    load(0, 1, 8'hC0);
    tick();
    cyc("t5.inrst", 1'b0, 2'd0, 1'b0, 8'h00);
    rst_n = 1'b1;
    #1;
    cyc("t5.idle", 1'b0, 2'd0, 1'b0, 8'h00);
    chk("t5.nowrite", 32'(wlog.size()), 32'd4);
    tick();
    cyc("t5.prio0", 1'b1, 2'd0, 1'b1, 8'hC0);
    tick();
    cyc("t5.rel", 1'b1, 2'd0, 1'b0, 8'h00);
    tick();
    cyc("t5.back3", 1'b1, 2'd3, 1'b1, 8'hB2);

    // Last-owner exclusion: 1 completes burst, 2 goes next
    do_reset();
    load(1, 5, 8'hD0);
    load(2, 2, 8'hE0);
    tick();
    for (int k = 0; k < 4; k++) begin
      cyc("t6.own1", 1'b1, 2'd1, 1'b1, 8'hD0 + 8'(k));
      tick();
    end
    cyc("t6.e0", 1'b1, 2'd2, 1'b1, 8'hE0);
    tick();
    cyc("t6.e1", 1'b1, 2'd2, 1'b1, 8'hE1);
    tick();
    cyc("t6.rel", 1'b1, 2'd2, 1'b0, 8'h00);
    tick();
    cyc("t6.d4", 1'b1, 2'd1, 1'b1, 8'hD4);

    chk("overflow", 32'(ovf), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
